// File: rtl/sound_ram_ctrl.sv
// Sound RAM controller: serialises CPU reads/writes onto a synchronous RAM port.
// Define SOUND_RAM_CLEAR_EN to add the RAM clear engine (reset and io_clear fill).
module sound_ram_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_cpu_rd,
  input  logic                  io_cpu_wr,
  input  logic [ADDR_WIDTH-1:0] io_cpu_addr,
  input  logic [DATA_WIDTH-1:0] io_cpu_din,
  output logic [DATA_WIDTH-1:0] io_cpu_dout,
  output logic                  io_cpu_ack,
  input  logic                  io_clear,
  output logic                  io_busy,
  output logic                  io_ram_rd,
  output logic                  io_ram_wr,
  output logic [ADDR_WIDTH-1:0] io_ram_addr,
  output logic [DATA_WIDTH-1:0] io_ram_din,
  input  logic [DATA_WIDTH-1:0] io_ram_dout
);

`ifdef SOUND_RAM_CLEAR_EN
  typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, WAIT, DONE} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                state, state_n;
  logic                  is_write, is_write_n;
  logic [DATA_WIDTH-1:0] cpu_dout_n;
  logic                  cpu_ack_n;
  logic                  ram_rd_n, ram_wr_n;
  logic [ADDR_WIDTH-1:0] ram_addr_n;
  logic [DATA_WIDTH-1:0] ram_din_n;

`ifdef SOUND_RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] counter, counter_n;
  logic                  pending, pending_n;

  assign io_busy = (state == CLEAR);
`else
  logic unused_clear;

  assign unused_clear = io_clear;
  assign io_busy      = 1'b0;
`endif

  // RAM strobes are computed for the state being entered, so they line up with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RESET_STATE;
      is_write    <= 1'b0;
      io_cpu_dout <= '0;
      io_cpu_ack  <= 1'b0;
      io_ram_rd   <= 1'b0;
      io_ram_wr   <= 1'b0;
      io_ram_addr <= '0;
      io_ram_din  <= '0;
`ifdef SOUND_RAM_CLEAR_EN
      counter     <= '0;
      pending     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      is_write    <= is_write_n;
      io_cpu_dout <= cpu_dout_n;
      io_cpu_ack  <= cpu_ack_n;
      io_ram_rd   <= ram_rd_n;
      io_ram_wr   <= ram_wr_n;
      io_ram_addr <= ram_addr_n;
      io_ram_din  <= ram_din_n;
`ifdef SOUND_RAM_CLEAR_EN
      counter     <= counter_n;
      pending     <= pending_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    is_write_n = is_write;
    cpu_dout_n = io_cpu_dout;
    cpu_ack_n  = 1'b0;
    ram_rd_n   = 1'b0;
    ram_wr_n   = 1'b0;
    ram_addr_n = io_ram_addr;
    ram_din_n  = io_ram_din;
`ifdef SOUND_RAM_CLEAR_EN
    counter_n  = counter;
    pending_n  = pending;
`endif
    unique case (state)
`ifdef SOUND_RAM_CLEAR_EN
      // Write lags the state by one cycle, so the last fill write lands in the first IDLE cycle
      CLEAR: begin
        ram_wr_n   = 1'b1;
        ram_addr_n = counter;
        ram_din_n  = CLEAR_VALUE;
        counter_n  = counter + 1'b1;
        if (counter == '1) state_n = IDLE;
      end
`endif
      IDLE: begin
`ifdef SOUND_RAM_CLEAR_EN
        if (pending || io_clear) begin
          state_n   = CLEAR;
          counter_n = '0;
          pending_n = 1'b0;
        end else
`endif
        if (io_cpu_wr || io_cpu_rd) begin
          state_n    = ACCESS;
          is_write_n = io_cpu_wr;
          ram_wr_n   = io_cpu_wr;
          ram_rd_n   = !io_cpu_wr;
          ram_addr_n = io_cpu_addr;
          ram_din_n  = io_cpu_din;
        end
      end
      ACCESS: state_n = WAIT;
      WAIT: begin
        if (!is_write) cpu_dout_n = io_ram_dout;
        cpu_ack_n = 1'b1;
        state_n   = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SOUND_RAM_CLEAR_EN
    if (state != IDLE && io_clear) pending_n = 1'b1;
`endif
  end

endmodule

// File: tb/tb_sound_ram_ctrl.sv
// Scoreboard bench for sound_ram_ctrl with a synchronous RAM model.
// Clear-engine scenarios are built only when SOUND_RAM_CLEAR_EN is defined.
module tb_sound_ram_ctrl;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SOUND_RAM_CLEAR_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_rd = 1'b0, cpu_wr = 1'b0, clear = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout, ram_din, ram_dout;
  logic          cpu_ack, busy, ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] last_dout = '0;
  int            total = 0, bad = 0;
  int            rd_pulses = 0, wr_pulses = 0, overlap = 0;
  logic          clr_watch = 1'b0;
  int            clr_count = 0, clr_err = 0;
  logic [AW-1:0] clr_next = '0;

  always #5 clock = ~clock;

  sound_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(8'h00)) dut (
    .clock(clock), .reset(reset),
    .io_cpu_rd(cpu_rd), .io_cpu_wr(cpu_wr), .io_cpu_addr(cpu_addr), .io_cpu_din(cpu_din),
    .io_cpu_dout(cpu_dout), .io_cpu_ack(cpu_ack),
    .io_clear(clear), .io_busy(busy),
    .io_ram_rd(ram_rd), .io_ram_wr(ram_wr), .io_ram_addr(ram_addr), .io_ram_din(ram_din),
    .io_ram_dout(ram_dout)
  );

  always @(posedge clock) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  // Bus monitor: strobe counts, overlap detection and the expected fill sequence
  always @(negedge clock) begin
    if (ram_rd) rd_pulses++;
    if (ram_wr) wr_pulses++;
    if (ram_rd && ram_wr) overlap++;
    if (clr_watch && ram_wr) begin
      if (ram_addr !== clr_next || ram_din !== 8'h00) clr_err++;
      clr_next++;
      clr_count++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] din, input int exp_rd, input int exp_wr,
                           input string name);
    int lat, rd0, wr0;
    logic [DW-1:0] e;
    if (wr) begin
      shadow[addr] = din;
      exp_q.push_back(last_dout);
    end else begin
      exp_q.push_back(shadow[addr]);
      last_dout = shadow[addr];
    end
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
    lat = 0;
    do begin tick(); lat++; end while (cpu_ack !== 1'b1 && lat < 50);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    total++;
    if (cpu_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_ack: no ack after %0d cycles, want ack", name, lat);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++;
      if (cpu_dout !== e) begin
        bad++;
        $display("[TB] FAIL %s_dout: got %h want %h", name, cpu_dout, e);
      end
      total++;
      if (lat !== 3) begin
        bad++;
        $display("[TB] FAIL %s_latency: got %0d want 3", name, lat);
      end
    end
    tick();
    total++;
    if (rd_pulses - rd0 !== exp_rd) begin
      bad++;
      $display("[TB] FAIL %s_ram_rd: got %0d strobes want %0d", name, rd_pulses - rd0, exp_rd);
    end
    total++;
    if (wr_pulses - wr0 !== exp_wr) begin
      bad++;
      $display("[TB] FAIL %s_ram_wr: got %0d strobes want %0d", name, wr_pulses - wr0, exp_wr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack: got %b want 0", cpu_ack); end
    total++; if (cpu_dout !== 8'h00) begin bad++; $display("[TB] FAIL rst_dout: got %h want 00", cpu_dout); end
    total++; if (ram_rd !== 1'b0) begin bad++; $display("[TB] FAIL rst_ram_rd: got %b want 0", ram_rd); end
    total++; if (ram_wr !== 1'b0) begin bad++; $display("[TB] FAIL rst_ram_wr: got %b want 0", ram_wr); end
    total++; if (ram_addr !== '0) begin bad++; $display("[TB] FAIL rst_ram_addr: got %h want 0", ram_addr); end
    total++; if (ram_din !== '0) begin bad++; $display("[TB] FAIL rst_ram_din: got %h want 0", ram_din); end
    total++; if (busy !== CLR_EN) begin bad++; $display("[TB] FAIL rst_busy: got %b want %b", busy, CLR_EN); end
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 13'h0123, 8'h5A, 0, 1, "wr_0123");
    do_access(1'b1, 1'b0, 13'h0123, 8'h00, 1, 0, "rd_0123");
    do_access(1'b1, 1'b0, 13'h0456, 8'h00, 1, 0, "rd_0456");
  endtask

  task automatic test_both_high();
    do_access(1'b1, 1'b1, 13'h1FFF, 8'hC3, 0, 1, "both_1fff");
    do_access(1'b1, 1'b0, 13'h1FFF, 8'h00, 1, 0, "rd_1fff");
  endtask

  // Request held through the ack must start a second access straight away
  task automatic test_back_to_back();
    int lat;
    logic [DW-1:0] e;
    exp_q.push_back(shadow[13'h0123]);
    exp_q.push_back(shadow[13'h0123]);
    last_dout = shadow[13'h0123];
    cpu_rd = 1'b1; cpu_addr = 13'h0123;
    for (int k = 0; k < 2; k++) begin
      lat = 0;
      do begin tick(); lat++; end while (cpu_ack !== 1'b1 && lat < 50);
      total++;
      if (cpu_ack !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ack%0d: no ack after %0d cycles, want ack", k, lat);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (cpu_dout !== e) begin bad++; $display("[TB] FAIL b2b_dout%0d: got %h want %h", k, cpu_dout, e); end
        total++;
        if (lat !== 3 + k) begin bad++; $display("[TB] FAIL b2b_latency%0d: got %0d want %0d", k, lat, 3 + k); end
      end
    end
    cpu_rd = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_random();
    logic w;
    logic [AW-1:0] a;
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 13'h0200 + 13'($urandom_range(0, 15));
      do_access(!w, w, a, 8'($urandom), w ? 0 : 1, w ? 1 : 0, $sformatf("rnd%0d", i));
    end
  endtask

`ifdef SOUND_RAM_CLEAR_EN
  task automatic check_clear_run(input string name);
    int n;
    clr_watch = 1'b1; clr_count = 0; clr_err = 0; clr_next = '0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin tick(); n++; end
    n = 0;
    while (busy === 1'b1 && n < DEPTH + 100) begin n++; tick(); end
    repeat (2) tick();
    clr_watch = 1'b0;
    total++; if (n !== DEPTH) begin bad++; $display("[TB] FAIL %s_busy_cycles: got %0d want %0d", name, n, DEPTH); end
    total++; if (clr_count !== DEPTH) begin bad++; $display("[TB] FAIL %s_writes: got %0d want %0d", name, clr_count, DEPTH); end
    total++; if (clr_err !== 0) begin bad++; $display("[TB] FAIL %s_sequence: got %0d bad writes want 0", name, clr_err); end
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h00;
  endtask

  task automatic test_initial_clear();
    reset = 1'b1;
    check_clear_run("init_clear");
  endtask

  task automatic test_clear_during_read();
    int lat;
    logic [DW-1:0] e;
    do_access(1'b0, 1'b1, 13'h0010, 8'h77, 0, 1, "pre_wr_0010");
    exp_q.push_back(shadow[13'h0010]);
    last_dout = shadow[13'h0010];
    cpu_rd = 1'b1; cpu_addr = 13'h0010;
    tick(); lat = 1; clear = 1'b1;
    tick(); lat = 2; clear = 1'b0;
    while (cpu_ack !== 1'b1 && lat < 50) begin tick(); lat++; end
    cpu_rd = 1'b0;
    total++;
    if (cpu_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clr_rd_ack: no ack after %0d cycles, want ack", lat);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (cpu_dout !== e) begin bad++; $display("[TB] FAIL clr_rd_dout: got %h want %h", cpu_dout, e); end
      total++; if (lat !== 3) begin bad++; $display("[TB] FAIL clr_rd_latency: got %0d want 3", lat); end
    end
    check_clear_run("clear_after_read");
    do_access(1'b1, 1'b0, 13'h0010, 8'h00, 1, 0, "rd_0010_cleared");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clear = 1'b1; tick(); clear = 1'b0;
    n = 0;
    while (!(ram_wr === 1'b1 && ram_addr === 13'h0800) && n < DEPTH + 100) begin tick(); n++; end
    total++;
    if (ram_addr !== 13'h0800) begin bad++; $display("[TB] FAIL midclr_reach: got addr %h want 0800", ram_addr); end
    reset = 1'b0;
    #1;
    last_dout = 8'h00;
    total++;
    if ({cpu_ack, cpu_dout, ram_rd, ram_wr, ram_addr, ram_din, busy} !== {1'b0, 8'h00, 1'b0, 1'b0, 13'h0, 8'h00, 1'b1}) begin
      bad++;
      $display("[TB] FAIL midclr_reset_vals: got ack=%b dout=%h rd=%b wr=%b addr=%h din=%h busy=%b want 0 00 0 0 0000 00 1",
               cpu_ack, cpu_dout, ram_rd, ram_wr, ram_addr, ram_din, busy);
    end
    tick();
    reset = 1'b1;
    check_clear_run("clear_restart");
  endtask

  task automatic test_stall_during_clear();
    int n, fall, rd0;
    logic [DW-1:0] e;
    clear = 1'b1; tick(); clear = 1'b0;
    exp_q.push_back(8'h00);
    last_dout = 8'h00;
    clr_watch = 1'b1; clr_count = 0; clr_err = 0; clr_next = '0;
    rd0 = rd_pulses;
    cpu_rd = 1'b1; cpu_addr = 13'h0123;
    n = 0; fall = -1;
    while (cpu_ack !== 1'b1 && n < DEPTH + 100) begin
      tick(); n++;
      if (fall < 0 && busy === 1'b0) fall = n;
    end
    cpu_rd = 1'b0;
    clr_watch = 1'b0;
    total++;
    if (cpu_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_ack: no ack after %0d cycles, want ack", n);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (cpu_dout !== e) begin bad++; $display("[TB] FAIL stall_dout: got %h want %h", cpu_dout, e); end
      total++; if (n - fall !== 3 || fall < 0) begin bad++; $display("[TB] FAIL stall_ack_delay: got %0d want 3 after busy fell", n - fall); end
    end
    total++; if (clr_count !== DEPTH) begin bad++; $display("[TB] FAIL stall_clear_writes: got %0d want %0d", clr_count, DEPTH); end
    total++; if (rd_pulses - rd0 !== 1) begin bad++; $display("[TB] FAIL stall_ram_rd: got %0d want 1", rd_pulses - rd0); end
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h00;
    tick();
  endtask
`else
  task automatic test_idle_after_reset();
    int wr0, busy_seen;
    wr0 = wr_pulses;
    busy_seen = 0;
    reset = 1'b1;
    repeat (5) begin tick(); if (busy !== 1'b0) busy_seen++; end
    total++; if (busy_seen !== 0) begin bad++; $display("[TB] FAIL idle_busy: got %0d busy cycles want 0", busy_seen); end
    total++; if (wr_pulses - wr0 !== 0) begin bad++; $display("[TB] FAIL idle_no_clear: got %0d writes want 0", wr_pulses - wr0); end
  endtask

  task automatic test_clear_ignored();
    int busy_seen;
    busy_seen = 0;
    clear = 1'b1;
    repeat (3) begin tick(); if (busy !== 1'b0) busy_seen++; end
    clear = 1'b0;
    total++; if (busy_seen !== 0) begin bad++; $display("[TB] FAIL clr_ignored_busy: got %0d busy cycles want 0", busy_seen); end
    do_access(1'b1, 1'b0, 13'h0123, 8'h00, 1, 0, "rd_after_clear_req");
  endtask
`endif

  task automatic test_final();
    total++; if (overlap !== 0) begin bad++; $display("[TB] FAIL rd_wr_overlap: got %0d cycles want 0", overlap); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = DW'(i) ^ 8'hA5;
      shadow[i] = DW'(i) ^ 8'hA5;
    end
    test_reset();
`ifdef SOUND_RAM_CLEAR_EN
    test_initial_clear();
`else
    test_idle_after_reset();
`endif
    test_write_read();
    test_both_high();
    test_back_to_back();
    test_random();
`ifdef SOUND_RAM_CLEAR_EN
    test_clear_during_read();
    test_reset_mid_clear();
    test_stall_during_clear();
    test_write_read();
`else
    test_clear_ignored();
`endif
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_ram_ctrl.md
SOUND_RAM_CTRL -- requirements
Module: sound_ram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 13, RAM address width; DATA_WIDTH, 8, RAM data width; CLEAR_VALUE, 0, word written during clear.
REQ-002 SHALL have ports (name direction width meaning), in this order:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_cpu_rd  in  1  CPU read request, level, held until ack.
- io_cpu_wr  in  1  CPU write request, level, held until ack.
- io_cpu_addr  in  ADDR_WIDTH  CPU address.
- io_cpu_din  in  DATA_WIDTH  CPU write data.
- io_cpu_dout  out  DATA_WIDTH  registered read data, valid while io_cpu_ack=1.
- io_cpu_ack  out  1  one-cycle completion pulse.
- io_clear  in  1  request to re-clear RAM.
- io_busy  out  1  clear in progress.
- io_ram_rd  out  1  RAM read strobe.
- io_ram_wr  out  1  RAM write strobe.
- io_ram_addr  out  ADDR_WIDTH  RAM address.
- io_ram_din  out  DATA_WIDTH  RAM write data.
- io_ram_dout  in  DATA_WIDTH  RAM read data, valid one cycle after io_ram_rd.

Function
REQ-003 SHALL implement FSM states CLEAR, IDLE, ACCESS, WAIT, DONE; all RAM-side outputs registered.
REQ-004 CLEAR: each cycle SHALL drive io_ram_wr=1, io_ram_addr=counter, io_ram_din=CLEAR_VALUE, counter+1; after address 2^ADDR_WIDTH-1 SHALL go to IDLE (exactly 2^ADDR_WIDTH writes, no wrap).
REQ-005 io_busy SHALL be 1 exactly while in CLEAR.
REQ-006 IDLE priority: pending clear > io_cpu_wr > io_cpu_rd; clear SHALL reset counter to 0 and enter CLEAR.
REQ-007 CPU request in IDLE SHALL latch addr/din/direction and enter ACCESS; rd and wr both high SHALL be treated as write.
REQ-008 ACCESS SHALL assert io_ram_rd or io_ram_wr for exactly one cycle with latched addr/din, then go to WAIT.
REQ-009 WAIT SHALL capture io_ram_dout into io_cpu_dout on reads (unchanged on writes), then go to DONE.
REQ-010 DONE SHALL assert io_cpu_ack for one cycle, then go to IDLE; request-to-ack latency 3 cycles from sampling edge.
REQ-011 Requester SHALL drop request the cycle after ack; a request still high in IDLE SHALL start a new access.
REQ-012 io_clear asserted outside IDLE SHALL set a pending flag; in-flight access SHALL complete and ack before clearing starts.
REQ-013 CPU requests during CLEAR SHALL stall (no ack, no RAM access) until clear completes.
REQ-014 io_ram_rd and io_ram_wr SHALL never be high together.

Reset
REQ-015 On reset low: state=CLEAR (IDLE if REQ-017 disabled), counter=0, pending=0, io_cpu_ack=0, io_cpu_dout=0, io_ram_rd=0, io_ram_wr=0, io_ram_addr=0, io_ram_din=0.
REQ-016 Reset mid-clear or mid-access SHALL abort immediately; clear restarts from address 0 after release.

Configuration
REQ-017 Macro SOUND_RAM_CLEAR_EN: defined -> CLEAR state, io_clear and pending flag present as above; undefined -> no CLEAR state, reset enters IDLE, io_clear ignored, io_busy tied 0.

Verification
REQ-018 Release reset (CLEAR_EN) -> 8192 consecutive writes of 0x00 to 0x0000..0x1FFF, io_busy high 8192 cycles, then IDLE.
REQ-019 Write 0x5A to 0x0123, then read 0x0123 -> each acked after 3 cycles; read ack carries io_cpu_dout=0x5A.
REQ-020 rd and wr both high, addr 0x1FFF, din 0xC3 -> single RAM write, no RAM read.
REQ-021 io_clear pulse during a read of 0x0010 -> read acked with correct data, then full 8192-cycle clear.
REQ-022 Reset asserted at clear address 0x0800 -> outputs at reset values; after release clear restarts at 0x0000.
REQ-023 CPU read held during clear -> no ack until io_busy falls, then ack 3 cycles after IDLE sample.
